// File: rtl/intersection_ctrl.sv
// Two-road intersection phase sequencer with pedestrian crossing and night flash mode.
// Optional side-road car sensor gating of main green: define SIDE_SENSOR_EN.
module intersection_ctrl #(
  parameter int TICK_DIV     = 50000000,
  parameter int MAIN_GREEN   = 15,
  parameter int SIDE_GREEN   = 10,
  parameter int YELLOW_TIME  = 5,
  parameter int ALL_RED_TIME = 2,
  parameter int PED_TIME     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       night_mode,
`ifdef SIDE_SENSOR_EN
  input  logic       side_car,
`endif
  output logic       main_r,
  output logic       main_y,
  output logic       main_g,
  output logic       side_r,
  output logic       side_y,
  output logic       side_g,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [7:0] sec_left
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    MAIN_G, MAIN_Y, ALL_R1, SIDE_G, SIDE_Y, ALL_R2, PED, NIGHT
  } state_t;

  state_t          state_q, state_d, nxt;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      sec_q, sec_d;
  logic            ped_q, ped_d;
  logic            blink_q, blink_d;
  logic [6:0]      lamp_q, lamp_d;
  logic            tick, advance;
`ifdef SIDE_SENSOR_EN
  logic            side_seen_q, side_seen_d;
`endif

  function automatic logic [7:0] dur(input state_t s);
    case (s)
      MAIN_G:          dur = 8'(MAIN_GREEN);
      MAIN_Y, SIDE_Y:  dur = 8'(YELLOW_TIME);
      ALL_R1, ALL_R2:  dur = 8'(ALL_RED_TIME);
      SIDE_G:          dur = 8'(SIDE_GREEN);
      PED:             dur = 8'(PED_TIME);
      default:         dur = 8'd0;
    endcase
  endfunction

  // Lamp order: main_r, main_y, main_g, side_r, side_y, side_g, ped_walk
  function automatic logic [6:0] lamps(input state_t s, input logic blink);
    case (s)
      MAIN_G:  lamps = 7'b001_100_0;
      MAIN_Y:  lamps = 7'b010_100_0;
      SIDE_G:  lamps = 7'b100_001_0;
      SIDE_Y:  lamps = 7'b100_010_0;
      PED:     lamps = 7'b100_100_1;
      NIGHT:   lamps = {1'b0, blink, 2'b00, blink, 2'b00};
      default: lamps = 7'b100_100_0;
    endcase
  endfunction

  always_comb begin
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    state_d = state_q;
    sec_d   = sec_q;
    blink_d = blink_q;
    advance = 1'b0;
    case (state_q)
      MAIN_G:  nxt = MAIN_Y;
      MAIN_Y:  nxt = ALL_R1;
      ALL_R1:  nxt = SIDE_G;
      SIDE_G:  nxt = SIDE_Y;
      SIDE_Y:  nxt = ALL_R2;
      ALL_R2:  nxt = night_mode ? NIGHT : (ped_q ? PED : MAIN_G);
      PED:     nxt = MAIN_G;
      default: nxt = ALL_R2;
    endcase
    if (tick) begin
      if (state_q == NIGHT) begin
        blink_d = ~blink_q;
        advance = ~night_mode;
      end else if (sec_q == 8'd1) begin
        advance = 1'b1;
`ifdef SIDE_SENSOR_EN
        // With no side demand, main green holds at 1 and retries every tick
        if (state_q == MAIN_G && !(side_seen_q || ped_q || night_mode))
          advance = 1'b0;
`endif
      end else if (sec_q != 8'd0) begin
        sec_d = sec_q - 8'd1;
      end
    end
    if (advance) begin
      state_d = nxt;
      presc_d = '0;
      sec_d   = dur(nxt);
      if (nxt == NIGHT) blink_d = 1'b0;
    end
    // Entering PED clears the request even if the button is pressed on that edge
    ped_d  = (ped_q || (ped_req && state_q != PED)) && !(advance && nxt == PED);
    lamp_d = lamps(state_d, blink_d);
`ifdef SIDE_SENSOR_EN
    side_seen_d = (side_seen_q || side_car) && !(advance && nxt == SIDE_G);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ALL_R2;
      presc_q <= '0;
      sec_q   <= 8'(ALL_RED_TIME);
      ped_q   <= 1'b0;
      blink_q <= 1'b0;
      lamp_q  <= 7'b100_100_0;
`ifdef SIDE_SENSOR_EN
      side_seen_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      ped_q   <= ped_d;
      blink_q <= blink_d;
      lamp_q  <= lamp_d;
`ifdef SIDE_SENSOR_EN
      side_seen_q <= side_seen_d;
`endif
    end
  end

  assign {main_r, main_y, main_g, side_r, side_y, side_g, ped_walk} = lamp_q;
  assign ped_ack  = ped_q;
  assign sec_left = sec_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl with TICK_DIV=4 and short phase durations.
module tb_intersection_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, ped_req, night_mode;
  logic       main_r, main_y, main_g, side_r, side_y, side_g, ped_walk, ped_ack;
  logic [7:0] sec_left;
`ifdef SIDE_SENSOR_EN
  logic       side_car;
`endif
  logic [6:0] lamps_w;
  int         checks = 0;
  int         errors = 0;

  localparam logic [6:0] L_MG  = 7'b001_100_0;
  localparam logic [6:0] L_MY  = 7'b010_100_0;
  localparam logic [6:0] L_AR  = 7'b100_100_0;
  localparam logic [6:0] L_SG  = 7'b100_001_0;
  localparam logic [6:0] L_SY  = 7'b100_010_0;
  localparam logic [6:0] L_PED = 7'b100_100_1;
  localparam logic [6:0] L_NY  = 7'b010_010_0;

  intersection_ctrl #(
    .TICK_DIV(4), .MAIN_GREEN(3), .SIDE_GREEN(2),
    .YELLOW_TIME(1), .ALL_RED_TIME(1), .PED_TIME(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .night_mode(night_mode),
`ifdef SIDE_SENSOR_EN
    .side_car(side_car),
`endif
    .main_r(main_r), .main_y(main_y), .main_g(main_g),
    .side_r(side_r), .side_y(side_y), .side_g(side_g),
    .ped_walk(ped_walk), .ped_ack(ped_ack), .sec_left(sec_left)
  );

  always #5 clk = ~clk;
  assign lamps_w = {main_r, main_y, main_g, side_r, side_y, side_g, ped_walk};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks cycles [from,to) of a phase lasting dur ticks; sec_left drops every 4 cycles.
  task automatic run(input string tag, input logic [6:0] lm, input int dur,
                     input logic ack, input int from, input int to);
    for (int i = from; i < to; i++) begin
      chk({tag, "_lamps"}, 32'(lamps_w), 32'(lm));
      chk({tag, "_sec"}, 32'(sec_left), 32'(dur - i / 4));
      chk({tag, "_ack"}, 32'(ped_ack), 32'(ack));
      @(negedge clk);
    end
  endtask

  task automatic night(input string tag, input int ncyc, input int drop_at, input logic ack);
    for (int i = 0; i < ncyc; i++) begin
      if (i == drop_at) night_mode = 1'b0;
      chk({tag, "_lamps"}, 32'(lamps_w), ((i / 4) % 2 == 1) ? 32'(L_NY) : 32'd0);
      chk({tag, "_sec"}, 32'(sec_left), 32'd0);
      chk({tag, "_ack"}, 32'(ped_ack), 32'(ack));
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; ped_req = 1'b0; night_mode = 1'b0;
`ifdef SIDE_SENSOR_EN
    side_car = 1'b1;
`endif
    repeat (2) @(negedge clk);
    chk("reset_lamps", 32'(lamps_w), 32'(L_AR));
    chk("reset_sec", 32'(sec_left), 32'd1);
    chk("reset_ack", 32'(ped_ack), 32'd0);
    rst_n = 1'b1;

    // Plain cycle, no requests
    run("c1_allr2", L_AR, 1, 0, 0, 4);
    run("c1_maing", L_MG, 3, 0, 0, 12);
    run("c1_mainy", L_MY, 1, 0, 0, 4);
    run("c1_allr1", L_AR, 1, 0, 0, 4);
    run("c1_sideg", L_SG, 2, 0, 0, 8);
    run("c1_sidey", L_SY, 1, 0, 0, 4);
    run("c1_allr2b", L_AR, 1, 0, 0, 4);

    // Pedestrian pulse during side green
    run("p_maing", L_MG, 3, 0, 0, 12);
    run("p_mainy", L_MY, 1, 0, 0, 4);
    run("p_allr1", L_AR, 1, 0, 0, 4);
    ped_req = 1'b1;
    run("p_sideg0", L_SG, 2, 0, 0, 1);
    ped_req = 1'b0;
    run("p_sideg", L_SG, 2, 1, 1, 8);
    run("p_sidey", L_SY, 1, 1, 0, 4);
    run("p_allr2", L_AR, 1, 1, 0, 4);
    run("p_walk", L_PED, 2, 0, 0, 8);

    // Night mode raised mid main green; cycle completes first
    run("n_maing0", L_MG, 3, 0, 0, 4);
    night_mode = 1'b1;
    run("n_maing", L_MG, 3, 0, 4, 12);
    run("n_mainy", L_MY, 1, 0, 0, 4);
    run("n_allr1", L_AR, 1, 0, 0, 4);
    run("n_sideg", L_SG, 2, 0, 0, 8);
    run("n_sidey", L_SY, 1, 0, 0, 4);
    run("n_allr2", L_AR, 1, 0, 0, 4);
    night("n_flash", 12, 8, 0);
    run("n_exit_allr2", L_AR, 1, 0, 0, 4);

    // Night and pedestrian both pending: night first, then walk
    night_mode = 1'b1;
    run("np_maing", L_MG, 3, 0, 0, 12);
    run("np_mainy", L_MY, 1, 0, 0, 4);
    run("np_allr1", L_AR, 1, 0, 0, 4);
    run("np_sideg", L_SG, 2, 0, 0, 8);
    ped_req = 1'b1;
    run("np_sidey0", L_SY, 1, 0, 0, 1);
    ped_req = 1'b0;
    run("np_sidey", L_SY, 1, 1, 1, 4);
    run("np_allr2", L_AR, 1, 1, 0, 4);
    night("np_flash", 8, 4, 1);
    run("np_exit_allr2", L_AR, 1, 1, 0, 4);
    run("np_walk", L_PED, 2, 0, 0, 8);

    // Reset pulse mid side green
    run("r_maing", L_MG, 3, 0, 0, 12);
    run("r_mainy", L_MY, 1, 0, 0, 4);
    run("r_allr1", L_AR, 1, 0, 0, 4);
    ped_req = 1'b1;
    run("r_sideg0", L_SG, 2, 0, 0, 1);
    ped_req = 1'b0;
    run("r_sideg", L_SG, 2, 1, 1, 3);
`ifdef SIDE_SENSOR_EN
    side_car = 1'b0;
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run("r_allr2", L_AR, 1, 0, 0, 4);
    run("r_maing2", L_MG, 3, 0, 0, 12);

`ifdef SIDE_SENSOR_EN
    // No side demand: main green holds at 1 until a car is seen
    for (int i = 0; i < 8; i++) begin
      chk("s_hold_lamps", 32'(lamps_w), 32'(L_MG));
      chk("s_hold_sec", 32'(sec_left), 32'd1);
      side_car = (i == 5);
      @(negedge clk);
    end
    side_car = 1'b0;
`endif
    run("r_mainy2", L_MY, 1, 0, 0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
